// File: rtl/bcd_display_controller.sv
// ---------------------------------------------------------------------------
// bcd_display_controller
//
// Accepts a 14-bit binary value through a valid/ready handshake, converts it
// to four BCD digits with a sequential double-dabble (one step per clock),
// latches the digits into display registers and multiplexes them onto a
// 4-digit common-anode 7-segment display.
//
// Parameters:
//   SCAN_DIV    - clock cycles each digit is driven while scanning (2..2^20)
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   value       - binary value to display (0..16383)
//   value_valid - value presented
//   value_ready - controller idle and able to accept a value
//   done        - one-cycle pulse when new digits reach the display registers
//   overflow    - last accepted value was greater than 9999 (shows 9999)
//   anode_n     - active-low digit enables, bit 0 = ones, bit 3 = thousands
//   seg_n       - active-low segments {g,f,e,d,c,b,a}
//
// Optional feature macro:
//   LEADING_ZERO_BLANK_EN - blank leading zeros of the upper three digits
// ---------------------------------------------------------------------------
module bcd_display_controller #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  anode_n,
    output logic [6:0]  seg_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [29:0] shift_reg;
    logic [3:0]  iter;
    logic [3:0]  digits [4];
    logic [19:0] prescaler;
    logic [1:0]  digit_idx;
    logic [3:0]  blank;
    logic        take;

    // One double-dabble iteration: correct every BCD field that would
    // overflow past 9 on doubling, then shift the whole register left.
    function automatic logic [29:0] dd_step(input logic [29:0] r);
        logic [29:0] t;
        t = r;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5)
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign value_ready = (state == IDLE);
    assign take        = value_valid && value_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. CONVERT leaves after the 14th step (iter == 13).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take) next_state = CONVERT;
            CONVERT: if (iter == 4'd13) next_state = LATCH;
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Conversion datapath and display digit registers. done is registered so
    // it coincides with the first cycle the new digits are on the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            iter      <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        shift_reg <= {16'd0, value};
                        iter      <= '0;
                        overflow  <= (value > 14'd9999);
                    end
                end
                CONVERT: begin
                    shift_reg <= dd_step(shift_reg);
                    iter      <= iter + 4'd1;
                end
                LATCH: begin
                    for (int i = 0; i < 4; i++)
                        digits[i] <= overflow ? 4'd9 : shift_reg[14 + 4*i +: 4];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan prescaler; the digit index steps on every wrap,
    // independent of conversion activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (prescaler == 20'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 20'd1;
        end
    end

    // A digit is blanked only if it and every digit to its left are zero;
    // the ones digit is never blanked.
    always_comb begin
        blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (digits[3] == 4'd0);
        blank[2] = blank[3] && (digits[2] == 4'd0);
        blank[1] = blank[2] && (digits[1] == 4'd0);
`endif
    end

    assign anode_n = ~(4'b0001 << digit_idx);
    assign seg_n   = blank[digit_idx] ? 7'b1111111 : encode(digits[digit_idx]);

endmodule
